// File: rtl/hd44780_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hd44780_responder_if                                          |
// | Purpose  : Character-LCD pin bus between a bus master and the            |
// |            HD44780-compatible responder.                                 |
// | Signals  : LCD_E        enable strobe (master, asynchronous to clk)      |
// |            LCD_RS       0 = instruction/status, 1 = data (master)        |
// |            LCD_RW       0 = write, 1 = read (master)                     |
// |            LCD_data_in  bus value driven by the master                   |
// |            LCD_data_out read value returned by the responder             |
// |            LCD_data_oe  high while the responder drives the bus          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface hd44780_responder_if;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_data_in;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;

  modport master (
    output LCD_E, LCD_RS, LCD_RW, LCD_data_in,
    input  LCD_data_out, LCD_data_oe
  );

  modport slave (
    input  LCD_E, LCD_RS, LCD_RW, LCD_data_in,
    output LCD_data_out, LCD_data_oe
  );
endinterface
`default_nettype wire

// File: rtl/hd44780_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hd44780_responder                                             |
// | Purpose  : Device side of a character-LCD pin bus. Emulates an          |
// |            HD44780-compatible controller: 80-byte linear DDRAM, address  |
// |            counter, entry-mode / display-control flags and busy flag,    |
// |            plus a second read port for a text renderer.                  |
// | Ports    : clk          system clock                                     |
// |            reset        synchronous active-high reset                    |
// |            lcd          pin bus (slave modport)                          |
// |            disp_addr    renderer character address                       |
// |            disp_data    DDRAM[disp_addr], 1-cycle latency, 0x20 if OOR   |
// |            display_on   D flag       cursor_on  C flag                   |
// |            blink_on     B flag       cursor_addr current AC              |
// |            busy         BF           overrun    sticky write-while-busy  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module hd44780_responder #(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000,
  parameter int DEPTH        = 80
) (
  input  wire logic             clk,
  input  wire logic             reset,
  hd44780_responder_if.slave    lcd,
  input  wire logic [6:0]       disp_addr,
  output logic      [7:0]       disp_data,
  output logic                  display_on,
  output logic                  cursor_on,
  output logic                  blink_on,
  output logic      [6:0]       cursor_addr,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_busy_load  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] c_clear_load = CNT_W'(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [6:0]       c_depth      = 7'(DEPTH);
  localparam logic [6:0]       c_last_addr  = 7'(DEPTH - 1);
  localparam logic [7:0]       c_space      = 8'h20;

  // Fill state machine
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  // Decoded instruction class
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_HOME  = 3'd2;
  localparam logic [2:0] OP_ENTRY = 3'd3;
  localparam logic [2:0] OP_DISP  = 3'd4;
  localparam logic [2:0] OP_SHIFT = 3'd5;
  localparam logic [2:0] OP_DDRAM = 3'd6;

  // ---------------------------------------------------------------------
  // Input capture: 2-flop synchronizers, third E flop for edge detection
  // ---------------------------------------------------------------------
  logic       e_s1_q, e_s2_q, e_s3_q;
  logic       rs_s1_q, rs_s2_q;
  logic       rw_s1_q, rw_s2_q;
  logic [7:0] data_s1_q, data_s2_q;
  // Bus values as last seen while synchronized E was high; these are what a
  // commit uses on the falling edge.
  logic       rs_h_q, rw_h_q;
  logic [7:0] data_h_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_s1_q    <= 1'b0;
      e_s2_q    <= 1'b0;
      e_s3_q    <= 1'b0;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
      rs_h_q    <= 1'b0;
      rw_h_q    <= 1'b0;
      data_h_q  <= 8'h00;
    end else begin
      e_s1_q    <= lcd.LCD_E;
      e_s2_q    <= e_s1_q;
      e_s3_q    <= e_s2_q;
      rs_s1_q   <= lcd.LCD_RS;
      rs_s2_q   <= rs_s1_q;
      rw_s1_q   <= lcd.LCD_RW;
      rw_s2_q   <= rw_s1_q;
      data_s1_q <= lcd.LCD_data_in;
      data_s2_q <= data_s1_q;
      if (e_s2_q) begin
        rs_h_q   <= rs_s2_q;
        rw_h_q   <= rw_s2_q;
        data_h_q <= data_s2_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  logic [6:0]       ac_q, ac_d;
  logic             id_q, id_d;
  logic             disp_on_q, disp_on_d;
  logic             cur_on_q, cur_on_d;
  logic             blink_q, blink_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [6:0]       fill_addr_q, fill_addr_d;
  logic [7:0]       data_out_q;
  logic             oe_q;
  logic [7:0]       disp_data_q;
  logic [7:0]       mem_q [DEPTH];

  // ---------------------------------------------------------------------
  // Commit decode
  // ---------------------------------------------------------------------
  logic       w_e_fall;
  logic       w_commit_wr, w_commit_rd;
  logic       w_wr_ok, w_data_wr, w_instr_wr, w_clear_start;
  logic       w_fill_we;
  logic [2:0] w_op;
  logic [6:0] w_ac_inc, w_ac_dec, w_ddram_ac;

  assign w_e_fall    = e_s3_q & ~e_s2_q;
  assign w_commit_wr = w_e_fall & ~rw_h_q;
  assign w_commit_rd = w_e_fall &  rw_h_q;
  assign w_wr_ok     = w_commit_wr & ~busy;
  assign w_data_wr   = w_wr_ok &  rs_h_q;
  assign w_instr_wr  = w_wr_ok & ~rs_h_q;

  // AC steps wrap within 0..DEPTH-1
  assign w_ac_inc   = (ac_q == c_last_addr) ? 7'd0 : ac_q + 7'd1;
  assign w_ac_dec   = (ac_q == 7'd0) ? c_last_addr : ac_q - 7'd1;
  assign w_ddram_ac = (data_h_q[6:0] >= c_depth) ? 7'd0 : data_h_q[6:0];

  // Instruction class is set by the highest set bit of the byte
  always_comb begin
    w_op = OP_NOP;
    casez (data_h_q)
      8'b1???????: w_op = OP_DDRAM;
      8'b0001????: w_op = OP_SHIFT;
      8'b00001???: w_op = OP_DISP;
      8'b000001??: w_op = OP_ENTRY;
      8'b0000001?: w_op = OP_HOME;
      8'b00000001: w_op = OP_CLEAR;
      default:     w_op = OP_NOP;   // function set, CGRAM address, 0x00
    endcase
  end

  assign w_clear_start = w_instr_wr & (w_op == OP_CLEAR);

  // ---------------------------------------------------------------------
  // Fill FSM: writes 0x20 across the whole DDRAM after reset and Clear
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_clear_start) state_d = S_FILL;
      S_FILL:  if (fill_addr_q == c_last_addr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_fill_we = 1'b0;
    case (state_q)
      S_FILL:  w_fill_we = 1'b1;
      default: w_fill_we = 1'b0;
    endcase
  end

  // Address is parked at zero while idle so each fill starts from 0
  assign fill_addr_d = w_fill_we ? fill_addr_q + 7'd1 : 7'd0;

  assign busy = w_fill_we | (cnt_q != '0);

  // ---------------------------------------------------------------------
  // Next-state for AC, flags, busy counter, overrun
  // ---------------------------------------------------------------------
  always_comb begin
    ac_d      = ac_q;
    id_d      = id_q;
    disp_on_d = disp_on_q;
    cur_on_d  = cur_on_q;
    blink_d   = blink_q;
    ovr_d     = ovr_q;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - c_cnt_one;

    if (w_commit_wr && busy) begin
      ovr_d = 1'b1;
    end

    if (w_data_wr) begin
      ac_d  = id_q ? w_ac_inc : w_ac_dec;
      cnt_d = c_busy_load;
    end else if (w_instr_wr) begin
      cnt_d = c_busy_load;
      case (w_op)
        OP_CLEAR: begin
          ac_d  = 7'd0;
          id_d  = 1'b1;
          cnt_d = c_clear_load;
        end
        OP_HOME: begin
          ac_d  = 7'd0;
          cnt_d = c_clear_load;
        end
        OP_ENTRY: id_d = data_h_q[1];
        OP_DISP: begin
          disp_on_d = data_h_q[2];
          cur_on_d  = data_h_q[1];
          blink_d   = data_h_q[0];
        end
        OP_SHIFT: begin
          // bit3=1 is a display shift, which has no visible effect here
          if (!data_h_q[3]) ac_d = data_h_q[2] ? w_ac_inc : w_ac_dec;
        end
        OP_DDRAM: ac_d = w_ddram_ac;
        default: ;
      endcase
    end else if (w_commit_rd && rs_h_q) begin
      ac_d = id_q ? w_ac_inc : w_ac_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ac_q        <= 7'd0;
      id_q        <= 1'b1;
      disp_on_q   <= 1'b0;
      cur_on_q    <= 1'b0;
      blink_q     <= 1'b0;
      ovr_q       <= 1'b0;
      cnt_q       <= '0;
      fill_addr_q <= 7'd0;
    end else begin
      ac_q        <= ac_d;
      id_q        <= id_d;
      disp_on_q   <= disp_on_d;
      cur_on_q    <= cur_on_d;
      blink_q     <= blink_d;
      ovr_q       <= ovr_d;
      cnt_q       <= cnt_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // ---------------------------------------------------------------------
  // DDRAM: one write port (fill or data write), two read ports
  // ---------------------------------------------------------------------
  logic       w_mem_we;
  logic [6:0] w_mem_waddr;
  logic [7:0] w_mem_wdata;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = ac_q;
    w_mem_wdata = data_h_q;
    if (w_fill_we) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = fill_addr_q;
      w_mem_wdata = c_space;
    end else if (w_data_wr) begin
      w_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Renderer port: a same-cycle write to the same address returns the old
  // byte, since the array update and this read share one clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data_q <= c_space;
    end else begin
      disp_data_q <= (disp_addr < c_depth) ? mem_q[disp_addr] : c_space;
    end
  end

  // Bus read path: data refreshed every cycle while a read strobe is high
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= 8'h00;
      oe_q       <= 1'b0;
    end else begin
      if (e_s2_q && rw_s2_q) begin
        data_out_q <= rs_s2_q ? mem_q[ac_q] : {busy, ac_q};
      end
      // e_s3_q delays the drive start to two clocks after the synced rise
      oe_q <= e_s2_q & e_s3_q & rw_s2_q;
    end
  end

  assign lcd.LCD_data_out = data_out_q;
  assign lcd.LCD_data_oe  = oe_q;
  assign disp_data        = disp_data_q;
  assign display_on       = disp_on_q;
  assign cursor_on        = cur_on_q;
  assign blink_on         = blink_q;
  assign cursor_addr      = ac_q;
  assign overrun          = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hd44780_responder                                          |
// | Purpose  : Self-checking bench for hd44780_responder: directed bus      |
// |            sequences plus randomized traffic against a behavioural      |
// |            model of the DDRAM, address counter and flags.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_hd44780_responder;

  localparam int BUSY_CYCLES  = 20;
  localparam int CLEAR_CYCLES = 200;
  localparam int DEPTH        = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] disp_addr;
  logic [7:0] disp_data;
  logic       display_on, cursor_on, blink_on, busy, overrun;
  logic [6:0] cursor_addr;

  hd44780_responder_if u_if ();

  hd44780_responder #(
    .BUSY_CYCLES  (BUSY_CYCLES),
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd         (u_if.slave),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .display_on  (display_on),
    .cursor_on   (cursor_on),
    .blink_on    (blink_on),
    .cursor_addr (cursor_addr),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Length of the most recent completed busy run, in clocks
  int run_len  = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (busy === 1'b1) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  // Behavioural model
  logic [7:0] m_mem [DEPTH];
  int         m_ac;
  bit         m_id, m_d, m_c, m_b, m_ovr;
  bit         clear_pending;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_mem[j]) m_mem[j] = 8'h20;
    m_ac = 0; m_id = 1; m_d = 0; m_c = 0; m_b = 0; m_ovr = 0;
    clear_pending = 0;
  endtask

  task automatic m_step(input bit up);
    m_ac = up ? (m_ac + 1) % DEPTH : (m_ac + DEPTH - 1) % DEPTH;
  endtask

  task automatic m_apply(input bit rs, input logic [7:0] d, input bit is_busy);
    if (is_busy) begin
      m_ovr = 1;
      return;
    end
    if (rs) begin
      m_mem[m_ac] = d;
      m_step(m_id);
    end else if (d >= 8'h80) m_ac = (int'(d[6:0]) >= DEPTH) ? 0 : int'(d[6:0]);
    else if (d >= 8'h20) begin end
    else if (d >= 8'h10) begin if (!d[3]) m_step(d[2]); end
    else if (d >= 8'h08) begin m_d = d[2]; m_c = d[1]; m_b = d[0]; end
    else if (d >= 8'h04) m_id = d[1];
    else if (d >= 8'h02) m_ac = 0;
    else if (d == 8'h01) begin
      foreach (m_mem[j]) m_mem[j] = 8'h20;
      m_ac = 0; m_id = 1; clear_pending = 1;
    end
  endtask

  // All bus tasks are entered and left on a falling clock edge
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 32'h0);
    clear_pending = 0;
  endtask

  task automatic bus_write(input bit rs, input logic [7:0] d);
    u_if.LCD_RS = rs; u_if.LCD_RW = 1'b0; u_if.LCD_data_in = d; u_if.LCD_E = 1'b1;
    repeat (5) @(negedge clk);
    u_if.LCD_E = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_read(input bit rs, output logic [7:0] v, output logic oe);
    u_if.LCD_RS = rs; u_if.LCD_RW = 1'b1; u_if.LCD_data_in = 8'h00; u_if.LCD_E = 1'b1;
    repeat (5) @(negedge clk);
    v  = u_if.LCD_data_out;
    oe = u_if.LCD_data_oe;
    u_if.LCD_E = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic disp_rd(input logic [6:0] a, output logic [7:0] v);
    disp_addr = a;
    @(negedge clk);
    v = disp_data;
  endtask

  task automatic do_write(input bit rs, input logic [7:0] d, input bit rush);
    if (!rush) wait_idle();
    m_apply(rs, d, rush);
    bus_write(rs, d);
  endtask

  task automatic do_read_data();
    logic [7:0] v;
    logic       oe;
    if (clear_pending) wait_idle();
    bus_read(1'b1, v, oe);
    check("rd_data", v, m_mem[m_ac]);
    check("rd_oe", oe, 1);
    m_step(m_id);
  endtask

  task automatic do_read_status();
    logic [7:0] v;
    logic       oe;
    wait_idle();
    bus_read(1'b0, v, oe);
    check("rd_status", v, m_ac);
  endtask

  task automatic check_state();
    check("cursor_addr", cursor_addr, m_ac);
    check("display_on", display_on, m_d);
    check("cursor_on", cursor_on, m_c);
    check("blink_on", blink_on, m_b);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic do_reset(output int nbusy);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    check("rst_ac", cursor_addr, 0);
    check("rst_flags", {display_on, cursor_on, blink_on}, 0);
    check("rst_overrun", overrun, 0);
    check("rst_oe", u_if.LCD_data_oe, 0);
    check("rst_data_out", u_if.LCD_data_out, 0);
    check("rst_disp_data", disp_data, 8'h20);
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 1000) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic dump_check(input string tag);
    logic [7:0] v;
    for (int a = 0; a < DEPTH; a++) begin
      disp_rd(7'(a), v);
      check(tag, v, m_mem[a]);
    end
  endtask

  initial begin
    logic [7:0] v;
    logic       oe;
    int         nb;
    bit         prev_acc_write;

    u_if.LCD_E = 1'b0; u_if.LCD_RS = 1'b0; u_if.LCD_RW = 1'b0; u_if.LCD_data_in = 8'h00;
    disp_addr = 7'd0;
    @(negedge clk);

    // Reset and power-on fill
    do_reset(nb);
    check("fill_busy_len", nb, DEPTH);
    disp_rd(7'd0, v);   check("disp_0", v, 8'h20);
    disp_rd(7'd79, v);  check("disp_79", v, 8'h20);
    disp_rd(7'd100, v); check("disp_oor", v, 8'h20);
    bus_read(1'b0, v, oe);
    check("status_after_reset", v, 8'h00);

    // Two data writes, status with and without busy
    do_write(1'b1, 8'h48, 1'b0);
    wait_idle();
    @(negedge clk);
    check("busy_len_write", last_run, BUSY_CYCLES);
    do_write(1'b1, 8'h69, 1'b0);
    bus_read(1'b0, v, oe);
    check("status_busy", v, 8'h82);
    wait_idle();
    bus_read(1'b0, v, oe);
    check("status_idle", v, 8'h02);
    disp_rd(7'd0, v); check("ddram_0", v, 8'h48);
    disp_rd(7'd1, v); check("ddram_1", v, 8'h69);
    check("ac_after_2", cursor_addr, 2);

    // Address set and wrap in both directions
    do_write(1'b0, 8'hCF, 1'b0);
    check("ac_cf", cursor_addr, 79);
    do_write(1'b1, 8'h41, 1'b0);
    disp_rd(7'd79, v); check("ddram_79", v, 8'h41);
    check("ac_wrap_up", cursor_addr, 0);
    do_write(1'b0, 8'h04, 1'b0);
    do_write(1'b1, 8'h42, 1'b0);
    disp_rd(7'd0, v); check("ddram_0_dec", v, 8'h42);
    check("ac_wrap_down", cursor_addr, 79);
    do_write(1'b0, 8'hD5, 1'b0);
    check("ac_oor", cursor_addr, 0);
    check_state();

    // Write while busy is dropped and sets sticky overrun
    do_write(1'b0, 8'h06, 1'b0);
    do_write(1'b1, 8'h55, 1'b0);
    do_write(1'b1, 8'h66, 1'b1);
    check("overrun_set", overrun, 1);
    check("ac_ignored", cursor_addr, 1);
    disp_rd(7'd1, v); check("ddram_ignored", v, 8'h69);
    do_write(1'b1, 8'h77, 1'b0);
    check("overrun_sticky", overrun, 1);
    check_state();

    // Display control and Clear
    do_write(1'b0, 8'h0E, 1'b0);
    check("flags_0e", {display_on, cursor_on, blink_on}, 3'b110);
    do_write(1'b0, 8'h04, 1'b0);
    do_write(1'b0, 8'h01, 1'b0);
    wait_idle();
    @(negedge clk);
    check("busy_len_clear", last_run, CLEAR_CYCLES);
    check("ac_clear", cursor_addr, 0);
    dump_check("clear_fill");
    do_write(1'b1, 8'h5A, 1'b0);
    check("id_after_clear", cursor_addr, 1);
    check_state();

    // Randomized traffic
    prev_acc_write = 0;
    for (int i = 0; i < 200; i++) begin
      int  k;
      bit  rush;
      logic [7:0] d;
      k    = $urandom_range(0, 9);
      rush = prev_acc_write && ($urandom_range(0, 3) == 0);
      if (k < 4) begin
        d = 8'($urandom_range(0, 255));
        do_write(1'b1, d, rush);
        prev_acc_write = !rush;
      end else if (k < 6) begin
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 15) == 0) d = 8'h01;
        do_write(1'b0, d, rush);
        prev_acc_write = !rush;
      end else if (k < 8) begin
        do_read_data();
        prev_acc_write = 0;
      end else begin
        do_read_status();
        prev_acc_write = 0;
      end
      check_state();
    end
    wait_idle();
    dump_check("random_ddram");
    disp_rd(7'd100, v); check("disp_oor_end", v, 8'h20);

    // Reset in the middle of a Clear fill
    do_write(1'b0, 8'h0F, 1'b0);
    do_write(1'b0, 8'h01, 1'b0);
    repeat (30) @(negedge clk);
    do_reset(nb);
    check("refill_busy_len", nb, DEPTH);
    check_state();
    disp_rd(7'd0, v);  check("refill_0", v, 8'h20);
    disp_rd(7'd40, v); check("refill_40", v, 8'h20);
    disp_rd(7'd79, v); check("refill_79", v, 8'h20);

    // Data read at AC=5
    do_write(1'b0, 8'h85, 1'b0);
    do_write(1'b1, 8'h77, 1'b0);
    do_write(1'b0, 8'h85, 1'b0);
    wait_idle();
    bus_read(1'b1, v, oe);
    check("read_ac5", v, 8'h77);
    check("read_ac5_oe", oe, 1);
    check("read_ac_step", cursor_addr, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hd44780_responder.md
Name: hd44780_responder

Overview:
- Device-side end of the character-LCD pin bus: behaves as an HD44780-compatible controller that responds to a bus master driving LCD_E, LCD_RS, LCD_RW and LCD_data.
- Holds an 80-byte linear DDRAM, an address counter, entry-mode and display-control flags, and a busy flag.
- Serves as the LCD emulation target in VGAtest: a second read port lets the VGA text renderer fetch characters.

Parameters:
- BUSY_CYCLES, 1850, busy duration after ordinary commands and data writes (37 us at 50 MHz).
- CLEAR_CYCLES, 76000, busy duration after Clear Display and Return Home (1.52 ms at 50 MHz).
- DEPTH, 80, number of DDRAM bytes. AC range is 0..DEPTH-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- LCD_E  in  1  enable strobe from bus master. Asynchronous to clk.
- LCD_RS  in  1  0 = instruction/status, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_data_in  in  8  bus value driven by master.
- LCD_data_out  out  8  read value returned to master.
- LCD_data_oe  out  1  high while responder drives the bus.
- disp_addr  in  7  renderer character address.
- disp_data  out  8  DDRAM[disp_addr]. Returns 0x20 for addresses >= DEPTH.
- display_on  out  1  D flag.
- cursor_on  out  1  C flag.
- blink_on  out  1  B flag.
- cursor_addr  out  7  current AC.
- busy  out  1  BF.
- overrun  out  1  sticky: a write arrived while busy.

Behaviour:
- Input capture:
  - LCD_E, LCD_RS, LCD_RW and LCD_data_in each pass through 2-flop synchronizers. A third E register provides edge detection.
  - Commit happens on the synchronized E falling edge, using RS/RW/data from the cycle before the fall.
  - Master must hold E high >= 4 clk and keep RS/RW/data stable from E rise to 4 clk after E fall.
- Reset:
  - AC=0, I/D=1, display_on=cursor_on=blink_on=0, overrun=0, LCD_data_oe=0, LCD_data_out=0, disp_data=0x20.
  - Then a fill sequence writes 0x20 to DDRAM[0..DEPTH-1], one byte per cycle; busy=1 during the fill.
  - busy=0 on the cycle after the last fill write. Reset asserted mid-anything restarts this sequence.
- Read (synchronized E high and RW=1):
  - LCD_data_oe=1 from 2 clk after E rise until synchronized E falls.
  - RS=0: LCD_data_out = {BF, AC[6:0]}.
  - RS=1: LCD_data_out = DDRAM[AC].
  - A data read (RS=1) steps AC on the E fall. Reads are honoured while busy and never set overrun.
- Write when busy=1: ignored (no state change). overrun is set to 1 and clears only on reset.
- Write when busy=0:
  - Data write (RS=1): DDRAM[AC] <= data. AC steps +1 (I/D=1) or -1 (I/D=0). AC wraps 79->0 and 0->79. Busy counter loads BUSY_CYCLES.
  - Instruction write (RS=0), decoded by highest set bit:
    - 0x01 Clear: fill DDRAM with 0x20 (DEPTH cycles), AC=0, I/D=1. Counter loads CLEAR_CYCLES.
    - 0x02-0x03 Home: AC=0, DDRAM unchanged. Counter loads CLEAR_CYCLES.
    - 0x04-0x07 Entry mode: I/D=bit1. Shift bit0 is ignored.
    - 0x08-0x0F Display control: D=bit2, C=bit1, B=bit0.
    - 0x10-0x1F Shift: if bit3=0, AC steps by bit2 (1=+1, 0=-1) with wrap. If bit3=1, no effect.
    - 0x20-0x3F Function set: accepted, no effect.
    - 0x40-0x7F CGRAM address: accepted, no effect.
    - 0x80-0xFF DDRAM address: AC=data[6:0]. A value >= DEPTH sets AC=0.
    - Every instruction other than Clear and Home loads BUSY_CYCLES.
- Busy counter: busy=1 on the cycle after the commit, for exactly the loaded count. Clear additionally holds busy until its fill completes.
- Display port:
  - disp_data is registered, 1-cycle latency.
  - When a DDRAM write and a disp read hit the same address in the same cycle, disp_data returns the old byte.
- Counter width: ceil(log2(CLEAR_CYCLES+1)) bits. No other arithmetic wider than 7 bits.

Test Plan:
- Reset 1 clk -> busy=1 for 80 clk then 0. disp_data=0x20 at addrs 0, 79 and 100. Status read returns 0x00.
- Data writes 0x48, 0x69, spaced >BUSY_CYCLES -> DDRAM[0]=0x48, DDRAM[1]=0x69, cursor_addr=2. Immediate status read shows 0x82; after BUSY_CYCLES it shows 0x02.
- Instr 0xCF (AC=79), data 0x41 -> DDRAM[79]=0x41, AC=0. Then 0x04, data 0x42 -> DDRAM[0]=0x42, AC=79. Instr 0xD5 (85) -> AC=0.
- Data write 1 clk after a prior commit (busy) -> DDRAM unchanged, overrun=1. overrun stays 1 through later good writes until reset.
- Instr 0x0E -> display_on=1, cursor_on=1, blink_on=0. Instr 0x01 -> all 80 bytes 0x20, AC=0, I/D=1, busy exactly CLEAR_CYCLES.
- Reset asserted mid-Clear fill -> fill restarts from 0, flags at reset values, overrun=0. Data read at AC=5 returns DDRAM[5] with oe high, and AC becomes 6.
